// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: shares one single-port external memory between CLIENTS delay
// lines. On each sample tick every client's read (and optional write) is
// snapshotted, then issued serially to memory; read data is collected in a
// staging buffer and published to the clients on the following tick.
//
// Ports:
//   clk_i, srst_i            clock, synchronous active-high reset
//   sample_tick_i            one-cycle strobe per audio sample
//   cl_write_enable_i        per-client write request
//   cl_write_address_i       per-client write address, client k at [k*AWIDTH +: AWIDTH]
//   cl_writedata_i           per-client write data
//   cl_read_address_i        per-client read address
//   cl_readdata_o            per-client read data, updated only on an accepted tick
//   mem_req_o/mem_we_o       memory request, 1 = write
//   mem_addr_o               {client index, client address}
//   mem_wrdata_o             memory write data
//   mem_ready_i              memory accepts the current request
//   mem_rddata_i/_valid_i    in-order read return
//   busy_o                   round in progress
//   overrun_o                sticky: tick arrived while a round was in progress
module ext_mem_arbiter #(
  parameter int unsigned CLIENTS   = 4,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned AWIDTH    = 16,
  parameter int unsigned CIDX_W    = (CLIENTS > 1) ? $clog2(CLIENTS) : 1,
  parameter int unsigned RDQ_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      sample_tick_i,
  input  logic [CLIENTS-1:0]        cl_write_enable_i,
  input  logic [CLIENTS*AWIDTH-1:0] cl_write_address_i,
  input  logic [CLIENTS*DWIDTH-1:0] cl_writedata_i,
  input  logic [CLIENTS*AWIDTH-1:0] cl_read_address_i,
  output logic [CLIENTS*DWIDTH-1:0] cl_readdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [CIDX_W+AWIDTH-1:0]  mem_addr_o,
  output logic [DWIDTH-1:0]         mem_wrdata_o,
  input  logic                      mem_ready_i,
  input  logic [DWIDTH-1:0]         mem_rddata_i,
  input  logic                      mem_rddata_valid_i,
  output logic                      busy_o,
  output logic                      overrun_o
);

  localparam int unsigned PTR_W = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RDQ_DEPTH + 1);
  localparam int unsigned MAW   = CIDX_W + AWIDTH;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    ISSUE_S = 2'd1,
    DRAIN_S = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CIDX_W-1:0]   cli_q, cli_d;
  logic                ph_q, ph_d;           // 0 = read phase, 1 = write phase

  logic [CLIENTS-1:0]  snap_we_q;
  logic [AWIDTH-1:0]   snap_waddr_q [CLIENTS];
  logic [DWIDTH-1:0]   snap_wdata_q [CLIENTS];
  logic [AWIDTH-1:0]   snap_raddr_q [CLIENTS];

  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [MAW-1:0]      addr_q, addr_d;
  logic [DWIDTH-1:0]   wrdata_q, wrdata_d;

  logic [CIDX_W-1:0]   rdq_q [RDQ_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DWIDTH-1:0]   stage_q [CLIENTS];
  logic [CLIENTS*DWIDTH-1:0] rd_out_q;
  logic                overrun_q, overrun_d;
  logic                busy_q;

  logic                hs, push, pop, snap_en;

  // Next-state, request and read-ID FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    cli_d     = cli_q;
    ph_d      = ph_q;
    overrun_d = overrun_q;
    snap_en   = 1'b0;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;

    hs   = req_q & mem_ready_i;
    push = hs & ~we_q;
    // A return with nothing outstanding is stray data and is dropped
    pop  = mem_rddata_valid_i & (cnt_q != '0);

    if (push) begin
      wptr_d = (wptr_q == PTR_W'(RDQ_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_W'(RDQ_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE_S: begin
        if (sample_tick_i) begin
          snap_en = 1'b1;
          state_d = ISSUE_S;
          cli_d   = '0;
          ph_d    = 1'b0;
        end
      end
      ISSUE_S: begin
        if (sample_tick_i) overrun_d = 1'b1;
        if (hs) begin
          if (!ph_q && snap_we_q[cli_q]) begin
            ph_d = 1'b1;
          end else if (cli_q == CIDX_W'(CLIENTS - 1)) begin
            state_d = DRAIN_S;
          end else begin
            cli_d = cli_q + CIDX_W'(1);
            ph_d  = 1'b0;
          end
        end
      end
      DRAIN_S: begin
        if (sample_tick_i) overrun_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase

    // Request is raised from the cycle after entering ISSUE_S so it is built
    // from settled snapshot registers; a read waits for a free FIFO slot.
    req_d    = (state_q == ISSUE_S) && (state_d == ISSUE_S) &&
               (ph_d || (cnt_d < CNT_W'(RDQ_DEPTH)));
    we_d     = ph_d;
    addr_d   = {cli_d, (ph_d ? snap_waddr_q[cli_d] : snap_raddr_q[cli_d])};
    wrdata_d = snap_wdata_q[cli_d];
  end

  // State, snapshot, FIFO, staging and output registers
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE_S;
      cli_q     <= '0;
      ph_q      <= 1'b0;
      snap_we_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      rd_out_q  <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int k = 0; k < CLIENTS; k++) begin
        snap_waddr_q[k] <= '0;
        snap_wdata_q[k] <= '0;
        snap_raddr_q[k] <= '0;
        stage_q[k]      <= '0;
      end
      for (int i = 0; i < RDQ_DEPTH; i++) begin
        rdq_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cli_q     <= cli_d;
      ph_q      <= ph_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      busy_q    <= (state_d != IDLE_S);

      if (snap_en) begin
        snap_we_q <= cl_write_enable_i;
        for (int k = 0; k < CLIENTS; k++) begin
          snap_waddr_q[k] <= cl_write_address_i[k*AWIDTH +: AWIDTH];
          snap_wdata_q[k] <= cl_writedata_i[k*DWIDTH +: DWIDTH];
          snap_raddr_q[k] <= cl_read_address_i[k*AWIDTH +: AWIDTH];
          rd_out_q[k*DWIDTH +: DWIDTH] <= stage_q[k];
        end
      end

      if (push) rdq_q[wptr_q] <= cli_q;
      if (pop)  stage_q[rdq_q[rptr_q]] <= mem_rddata_i;
    end
  end

  assign cl_readdata_o = rd_out_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wrdata_o  = wrdata_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Scoreboard bench for ext_mem_arbiter: a memory responder drives ready/read
// data, expected accesses and published read data come from a sample-level
// reference model and are checked by the negedge monitor.
module tb_ext_mem_arbiter;

  localparam int unsigned CLIENTS   = 4;
  localparam int unsigned DWIDTH    = 16;
  localparam int unsigned AWIDTH    = 16;
  localparam int unsigned CIDX_W    = 2;
  localparam int unsigned RDQ_DEPTH = 2;
  localparam int unsigned MAW       = CIDX_W + AWIDTH;

  logic                      clk = 1'b0;
  logic                      srst_i = 1'b1;
  logic                      sample_tick_i = 1'b0;
  logic [CLIENTS-1:0]        cl_write_enable_i = '0;
  logic [CLIENTS*AWIDTH-1:0] cl_write_address_i = '0;
  logic [CLIENTS*DWIDTH-1:0] cl_writedata_i = '0;
  logic [CLIENTS*AWIDTH-1:0] cl_read_address_i = '0;
  logic [CLIENTS*DWIDTH-1:0] cl_readdata_o;
  logic                      mem_req_o;
  logic                      mem_we_o;
  logic [MAW-1:0]            mem_addr_o;
  logic [DWIDTH-1:0]         mem_wrdata_o;
  logic                      mem_ready_i = 1'b0;
  logic [DWIDTH-1:0]         mem_rddata_i = '0;
  logic                      mem_rddata_valid_i = 1'b0;
  logic                      busy_o;
  logic                      overrun_o;

  ext_mem_arbiter #(
    .CLIENTS(CLIENTS), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .CIDX_W(CIDX_W), .RDQ_DEPTH(RDQ_DEPTH)
  ) dut (
    .clk_i(clk), .srst_i(srst_i), .sample_tick_i(sample_tick_i),
    .cl_write_enable_i(cl_write_enable_i), .cl_write_address_i(cl_write_address_i),
    .cl_writedata_i(cl_writedata_i), .cl_read_address_i(cl_read_address_i),
    .cl_readdata_o(cl_readdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wrdata_o(mem_wrdata_o), .mem_ready_i(mem_ready_i),
    .mem_rddata_i(mem_rddata_i), .mem_rddata_valid_i(mem_rddata_valid_i),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic             we;
    logic [MAW-1:0]   addr;
    logic [DWIDTH-1:0] data;
  } acc_t;

  typedef struct {
    logic [DWIDTH-1:0] data;
    int                due;
  } rd_t;

  acc_t                       exp_acc[$];
  logic [CLIENTS*DWIDTH-1:0]  exp_pub[$];
  rd_t                        pend[$];
  logic [DWIDTH-1:0]          fmem [int];
  logic [DWIDTH-1:0]          ref_mem [int];

  int cmp_n = 0;
  int err_n = 0;

  // Memory responder / monitor state
  int   ready_mode = 0;
  int   lat = 3;
  int   stall_cnt = 0;
  int   cyc = 0;
  int   q_cnt = 0;
  int   last_due = 0;
  bit   spur_req = 1'b0;
  bit   expect_drop = 1'b0;
  bit   pub_chk = 1'b0;
  bit   ovr_chk = 1'b0;
  bit   prev_stall = 1'b0;
  logic              prev_we;
  logic [MAW-1:0]    prev_addr;
  logic [DWIDTH-1:0] prev_wrdata;

  // Reference model state
  logic [CLIENTS*DWIDTH-1:0] staged_m = '0;
  logic [CLIENTS-1:0]        st_we;
  logic [AWIDTH-1:0]         st_wa [CLIENTS];
  logic [DWIDTH-1:0]         st_wd [CLIENTS];
  logic [AWIDTH-1:0]         st_ra [CLIENTS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    cmp_n++;
    err_n++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [DWIDTH-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [DWIDTH-1:0] fmem_rd(input int a);
    return fmem.exists(a) ? fmem[a] : '0;
  endfunction

  // Memory model and scoreboard monitor, all decisions away from posedge
  always @(negedge clk) begin
    logic              r, v;
    logic [DWIDTH-1:0] d;
    int                cnt_before;
    acc_t              a;
    rd_t               e;
    cyc++;

    if (pub_chk) begin
      if (exp_pub.size() == 0) fail("pub_unexpected");
      else check("cl_readdata", 64'(cl_readdata_o), 64'(exp_pub.pop_front()));
      pub_chk = 1'b0;
    end
    if (ovr_chk) begin
      check("overrun_after_tick", 64'(overrun_o), 64'(1));
      ovr_chk = 1'b0;
    end
    if (prev_stall) begin
      check("stall_req", 64'(mem_req_o), 64'(1));
      check("stall_we", 64'(mem_we_o), 64'(prev_we));
      check("stall_addr", 64'(mem_addr_o), 64'(prev_addr));
      check("stall_wrdata", 64'(mem_wrdata_o), 64'(prev_wrdata));
    end

    case (ready_mode)
      0: r = 1'b1;
      1: begin
        if (mem_req_o && stall_cnt < 4) begin
          r = 1'b0;
          stall_cnt++;
        end else begin
          r = mem_req_o;
          stall_cnt = 0;
        end
      end
      default: r = ($urandom_range(0, 3) != 0);
    endcase

    cnt_before = q_cnt;
    if (mem_req_o && r && !srst_i) begin
      if (exp_acc.size() == 0) begin
        fail("unexpected_access");
      end else begin
        a = exp_acc.pop_front();
        check("acc_we", 64'(mem_we_o), 64'(a.we));
        check("acc_addr", 64'(mem_addr_o), 64'(a.addr));
        if (a.we) check("acc_wrdata", 64'(mem_wrdata_o), 64'(a.data));
      end
      if (mem_we_o) begin
        fmem[int'(mem_addr_o)] = mem_wrdata_o;
      end else begin
        check("rdq_limit", 64'(cnt_before < int'(RDQ_DEPTH)), 64'(1));
        q_cnt++;
        e.data = fmem_rd(int'(mem_addr_o));
        e.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = e.due;
        pend.push_back(e);
      end
    end

    v = 1'b0;
    d = DWIDTH'($urandom);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      v = 1'b1;
      d = pend[0].data;
      void'(pend.pop_front());
    end else if (spur_req && pend.size() == 0) begin
      v = 1'b1;
      d = 16'hFFFF;
      spur_req = 1'b0;
    end
    if (v && cnt_before > 0) q_cnt--;
    if (srst_i) q_cnt = 0;

    mem_ready_i        = r;
    mem_rddata_valid_i = v;
    mem_rddata_i       = d;

    prev_stall  = mem_req_o && !r && !srst_i;
    prev_we     = mem_we_o;
    prev_addr   = mem_addr_o;
    prev_wrdata = mem_wrdata_o;

    if (sample_tick_i) begin
      pub_chk = 1'b1;
      if (expect_drop) ovr_chk = 1'b1;
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 3000) begin
      cyc_wait(1);
      t++;
    end
    if (busy_o) fail("idle_timeout");
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < CLIENTS; k++) begin
      st_we[k] = 1'($urandom);
      st_wa[k] = AWIDTH'($urandom_range(0, 15));
      st_wd[k] = DWIDTH'($urandom);
      st_ra[k] = AWIDTH'($urandom_range(0, 15));
    end
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < CLIENTS; k++) begin
      cl_write_enable_i[k]                   = st_we[k];
      cl_write_address_i[k*AWIDTH +: AWIDTH] = st_wa[k];
      cl_writedata_i[k*DWIDTH +: DWIDTH]     = st_wd[k];
      cl_read_address_i[k*AWIDTH +: AWIDTH]  = st_ra[k];
    end
  endtask

  // Accepted tick: publish last round's reads, queue this round's accesses
  task automatic do_tick();
    logic [CLIENTS*DWIDTH-1:0] nxt;
    logic [MAW-1:0]            ka;
    wait_idle();
    nxt = '0;
    exp_pub.push_back(staged_m);
    for (int k = 0; k < CLIENTS; k++) begin
      ka = {CIDX_W'(k), st_ra[k]};
      nxt[k*DWIDTH +: DWIDTH] = ref_rd(int'(ka));
      exp_acc.push_back('{1'b0, ka, DWIDTH'(0)});
      if (st_we[k]) begin
        ka = {CIDX_W'(k), st_wa[k]};
        ref_mem[int'(ka)] = st_wd[k];
        exp_acc.push_back('{1'b1, ka, st_wd[k]});
      end
    end
    staged_m = nxt;
    apply_inputs();
    sample_tick_i = 1'b1;
    cyc_wait(1);
    sample_tick_i = 1'b0;
  endtask

  // Tick during a round: readdata must keep the last published value
  task automatic drop_tick(input logic [CLIENTS*DWIDTH-1:0] last_pub);
    exp_pub.push_back(last_pub);
    rand_inputs();
    apply_inputs();
    expect_drop   = 1'b1;
    sample_tick_i = 1'b1;
    cyc_wait(1);
    sample_tick_i = 1'b0;
    expect_drop   = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req"}, 64'(mem_req_o), 64'(0));
    check({tag, "_we"}, 64'(mem_we_o), 64'(0));
    check({tag, "_addr"}, 64'(mem_addr_o), 64'(0));
    check({tag, "_wrdata"}, 64'(mem_wrdata_o), 64'(0));
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_overrun"}, 64'(overrun_o), 64'(0));
    check({tag, "_readdata"}, 64'(cl_readdata_o), 64'(0));
  endtask

  initial begin
    logic [CLIENTS*DWIDTH-1:0] pub_before;
    int t;

    cyc_wait(3);
    check_zero_outputs("reset");
    srst_i = 1'b0;

    fmem[int'({2'd0, 16'd5})]    = 16'h1111;
    ref_mem[int'({2'd0, 16'd5})] = 16'h1111;
    fmem[int'({2'd1, 16'd7})]    = 16'hBEEF;
    ref_mem[int'({2'd1, 16'd7})] = 16'hBEEF;

    // Directed round, ready tied high, short latency
    ready_mode = 0;
    lat = 3;
    rand_inputs();
    st_we = 4'b0001;
    st_wa[0] = 16'd5; st_wd[0] = 16'h1234; st_ra[0] = 16'd5; st_ra[1] = 16'd7;
    do_tick();
    rand_inputs();
    do_tick();

    // Same pattern with every request stalled
    ready_mode = 1;
    rand_inputs();
    st_we = 4'b0001;
    st_wa[0] = 16'd5; st_wd[0] = 16'h4321; st_ra[0] = 16'd5; st_ra[1] = 16'd7;
    do_tick();
    rand_inputs();
    do_tick();

    // Random ready with long latency: read FIFO fills up
    ready_mode = 2;
    lat = 10;
    repeat (12) begin
      rand_inputs();
      do_tick();
    end

    // Overrun: second tick while the round is in flight
    rand_inputs();
    do_tick();
    pub_before = exp_pub[exp_pub.size() - 1];
    cyc_wait(2);
    check("busy_before_drop", 64'(busy_o), 64'(1));
    drop_tick(pub_before);
    wait_idle();
    check("overrun_sticky_idle", 64'(overrun_o), 64'(1));
    rand_inputs();
    do_tick();
    wait_idle();
    check("overrun_sticky_next", 64'(overrun_o), 64'(1));

    // Stray read data while idle must not touch staging
    cyc_wait(2);
    spur_req = 1'b1;
    cyc_wait(4);
    rand_inputs();
    do_tick();
    rand_inputs();
    do_tick();

    // Reset while reads are still outstanding in DRAIN_S
    wait_idle();
    ready_mode = 0;
    lat = 10;
    rand_inputs();
    st_we[2] = 1'b0;
    st_we[3] = 1'b0;
    do_tick();
    t = 0;
    while (!(exp_acc.size() == 0 && busy_o && !mem_req_o && pend.size() > 0) && t < 500) begin
      cyc_wait(1);
      t++;
    end
    if (t >= 500) fail("drain_wait_timeout");
    srst_i = 1'b1;
    cyc_wait(1);
    srst_i = 1'b0;
    check_zero_outputs("midreset");
    staged_m = '0;
    t = 0;
    while (pend.size() > 0 && t < 100) begin
      cyc_wait(1);
      t++;
    end
    cyc_wait(2);
    rand_inputs();
    do_tick();
    rand_inputs();
    do_tick();
    wait_idle();
    cyc_wait(5);

    check("acc_queue_drained", 64'(exp_acc.size()), 64'(0));
    check("pub_queue_drained", 64'(exp_pub.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
